palette_lut_multiport: RTL and testbench
========================================

// Module: palette_lut_multiport
// PURPOSE
//   Multi-channel palette lookup: maps N pixel indices per clock to colours from one palette RAM.
//   Sits between the framebuffer readout and the video output stage; host/CPU side rewrites entries.
//   Generalises the single-read palette: N read channels, masked writes with valid/ready handshake,
//   self-clear FSM (auto-runs after reset, host-triggerable), per-channel valid pipeline.
//   Single clock domain; storage is one RAM copy per read channel, all copies written in lockstep.
// PARAMETERS
//   PALETTE_LENGTH  256     number of entries (power of 2, >=2); IDX_BITS = $clog2(PALETTE_LENGTH)
//   COLOR_BITS      16      bits per colour; BYTES_PER_COLOR = (COLOR_BITS-1)/8+1
//   NUM_CHANNELS    2       independent read channels (>=1)
//   CLEAR_COLOR     '0      COLOR_BITS value written to every entry by the clear FSM
// PORTS
//   clk             in   1                          sole clock, rising edge
//   reset_n         in   1                          asynchronous, active-low reset
//   wr_valid        in   1                          host write request
//   wr_ready        out  1                          write accepted when wr_valid && wr_ready
//   wr_index        in   IDX_BITS                   entry to write
//   wr_color        in   COLOR_BITS                 write data
//   wr_byte_en      in   BYTES_PER_COLOR            byte mask; bit b covers wr_color[8b+:8] (top byte may be partial)
//   clear_start     in   1                          1-cycle pulse: fill palette with CLEAR_COLOR
//   clear_busy      out  1                          high while clear FSM is sweeping
//   rd_en           in   NUM_CHANNELS               per-channel lookup request
//   rd_index        in   NUM_CHANNELS x IDX_BITS    per-channel palette index
//   rd_color_valid  out  NUM_CHANNELS               per-channel result valid
//   rd_color        out  NUM_CHANNELS x COLOR_BITS  per-channel looked-up colour
// BEHAVIOUR
//   Reset (reset_n low, async): clear_busy=1, wr_ready=0, rd_color_valid=0, rd_color=0, clear_ptr=0,
//     FSM=CLEAR. RAM contents are not reset; the post-reset CLEAR sweep defines them.
//   FSM IDLE: wr_ready=1, clear_busy=0. clear_start=1 -> CLEAR next cycle, clear_ptr=0; a write
//     handshaken in that same cycle is performed, then overwritten by the sweep.
//   FSM CLEAR: writes CLEAR_COLOR (all bytes) to entry clear_ptr each cycle, clear_ptr++.
//     After writing PALETTE_LENGTH-1 -> IDLE; sweep takes exactly PALETTE_LENGTH cycles.
//     wr_ready=0, clear_busy=1; clear_start ignored (no restart).
//   Write: on handshake, for each set wr_byte_en bit, that byte of entry wr_index is updated in all
//     channel copies at that edge; unmasked bytes unchanged. wr_byte_en=0 is a legal no-op handshake.
//   Read: latency 2 per channel. Cycle t: rd_en[c] sampled, index registered into RAM address.
//     Cycle t+1: RAM output. Cycle t+2: rd_color[c]/rd_color_valid[c] registered.
//     Fully pipelined: one lookup per channel per cycle; channels independent.
//     rd_color holds its last value when rd_color_valid=0.
//   Read/write collision: a write at edge t is visible to a lookup whose rd_en is sampled at edge t+1
//     or later. A lookup sampled at the same edge as a write to the same entry returns the old
//     value (read-first); the same rule applies to clear-sweep writes.
//   Reads are permitted during CLEAR: each entry returns either its old value or CLEAR_COLOR,
//     depending on whether the sweep has already passed it (per the collision rule).
//   Index width equals IDX_BITS exactly: no out-of-range indices, no wrap logic required.
//   Reset mid-sweep or mid-pipeline: in-flight reads are dropped (valid=0), and a fresh full sweep
//     starts from entry 0 after reset_n rises.
// TESTING
//   1 reset_n low 3 cycles, then high -> clear_busy=1 for exactly 256 cycles, wr_ready=0 during sweep;
//     afterwards read every index on both channels -> all rd_color = CLEAR_COLOR.
//   2 write idx 5=16'hABCD (be=2'b11); next cycle rd_en=2'b11, rd_index={5,5} ->
//     2 cycles later both rd_color=16'hABCD, rd_color_valid=2'b11.
//   3 idx 7=16'h1234, then write 16'hFF00 with be=2'b10 -> read idx 7 returns 16'hFF34.
//   4 in the same cycle, write idx 9=16'h5555 (old value 16'h0000) and rd_en ch0 idx 9 -> ch0 returns
//     16'h0000; a read issued the next cycle returns 16'h5555.
//   5 back-to-back reads on ch0 of idx 0..255 (incrementing), random indices on ch1 ->
//     one valid result per cycle per channel, in order, matching a reference model.
//   6 clear_start mid-traffic, second clear_start at sweep cycle 100, reset_n pulsed low at cycle 150
//     -> second pulse ignored; after reset, a full 256-cycle sweep restarts from entry 0 with valids 0.

Source files
------------

// File: rtl/palette_lut_multiport.sv
// Multi-channel palette lookup: N independent 2-cycle read pipelines over per-channel RAM copies,
// written in lockstep by host byte-masked writes or by the self-clear sweep.
module palette_lut_multiport #(
  parameter int unsigned           PALETTE_LENGTH  = 256,
  parameter int unsigned           COLOR_BITS      = 16,
  parameter int unsigned           NUM_CHANNELS    = 2,
  parameter logic [COLOR_BITS-1:0] CLEAR_COLOR     = '0,
  localparam int unsigned          IDX_BITS        = $clog2(PALETTE_LENGTH),
  localparam int unsigned          BYTES_PER_COLOR = (COLOR_BITS - 1) / 8 + 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [IDX_BITS-1:0]                  wr_index,
  input  logic [COLOR_BITS-1:0]                wr_color,
  input  logic [BYTES_PER_COLOR-1:0]           wr_byte_en,
  input  logic                                 clear_start,
  output logic                                 clear_busy,
  input  logic [NUM_CHANNELS-1:0]              rd_en,
  input  logic [NUM_CHANNELS*IDX_BITS-1:0]     rd_index,
  output logic [NUM_CHANNELS-1:0]              rd_color_valid,
  output logic [NUM_CHANNELS*COLOR_BITS-1:0]   rd_color
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(PALETTE_LENGTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_BITS-1:0]   r_clear_ptr;
  logic [IDX_BITS-1:0]   w_clear_ptr_nxt;
  logic                  r_wr_ready;
  logic                  r_clear_busy;

  logic                  w_mem_we;
  logic [IDX_BITS-1:0]   w_mem_idx;
  logic [COLOR_BITS-1:0] w_mem_data;
  logic [COLOR_BITS-1:0] w_mem_mask;
  logic [COLOR_BITS-1:0] w_byte_mask;

  // Expand byte enables to a per-bit mask; the top byte may be partial.
  always_comb begin
    w_byte_mask = '0;
    for (int unsigned i = 0; i < COLOR_BITS; i++) begin
      w_byte_mask[i] = wr_byte_en[i / 8];
    end
  end

  // Next-state and shared RAM write port: sweep owns the port while clearing.
  always_comb begin
    w_state_nxt     = r_state;
    w_clear_ptr_nxt = r_clear_ptr;
    w_mem_we        = 1'b0;
    w_mem_idx       = wr_index;
    w_mem_data      = wr_color;
    w_mem_mask      = w_byte_mask;
    if (r_state == S_CLEAR) begin
      w_mem_we        = 1'b1;
      w_mem_idx       = r_clear_ptr;
      w_mem_data      = CLEAR_COLOR;
      w_mem_mask      = '1;
      w_clear_ptr_nxt = r_clear_ptr + IDX_BITS'(1);
      if (r_clear_ptr == LAST_IDX) begin
        w_state_nxt = S_IDLE;
      end
    end else begin
      w_mem_we = wr_valid && r_wr_ready;
      if (clear_start) begin
        w_state_nxt     = S_CLEAR;
        w_clear_ptr_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_CLEAR;
      r_clear_ptr  <= '0;
      r_wr_ready   <= 1'b0;
      r_clear_busy <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_clear_ptr  <= w_clear_ptr_nxt;
      r_wr_ready   <= (w_state_nxt == S_IDLE);
      r_clear_busy <= (w_state_nxt == S_CLEAR);
    end
  end

  assign wr_ready   = r_wr_ready;
  assign clear_busy = r_clear_busy;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [COLOR_BITS-1:0] r_mem [PALETTE_LENGTH];
    logic [COLOR_BITS-1:0] r_q1;
    logic [COLOR_BITS-1:0] r_q2;
    logic [COLOR_BITS-1:0] r_color;
    logic                  r_v1;
    logic                  r_v2;
    logic                  r_valid;

    // Read-first: the lookup sampled at a write edge sees the pre-write contents.
    always_ff @(posedge clk) begin
      if (w_mem_we) begin
        r_mem[w_mem_idx] <= (r_mem[w_mem_idx] & ~w_mem_mask) | (w_mem_data & w_mem_mask);
      end
      r_q1 <= r_mem[rd_index[c*IDX_BITS +: IDX_BITS]];
      r_q2 <= r_q1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_v1    <= 1'b0;
        r_v2    <= 1'b0;
        r_valid <= 1'b0;
        r_color <= '0;
      end else begin
        r_v1    <= rd_en[c];
        r_v2    <= r_v1;
        r_valid <= r_v2;
        if (r_v2) begin
          r_color <= r_q2;
        end
      end
    end

    assign rd_color_valid[c]                      = r_valid;
    assign rd_color[c*COLOR_BITS +: COLOR_BITS]   = r_color;
  end

endmodule

// File: tb/tb_palette_lut_multiport.sv
// Randomised bench for palette_lut_multiport: a behavioural palette model checked every cycle,
// plus hand-computed lookups for the basic write/read/collision cases.
module tb_palette_lut_multiport;

  localparam int unsigned PL = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_index = '0;
  logic [15:0] wr_color = '0;
  logic [1:0]  wr_byte_en = '0;
  logic        clear_start = 1'b0;
  logic        clear_busy;
  logic [1:0]  rd_en = '0;
  logic [15:0] rd_index = '0;
  logic [1:0]  rd_color_valid;
  logic [31:0] rd_color;

  int errors = 0;
  int checks = 0;

  palette_lut_multiport dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_index       (wr_index),
    .wr_color       (wr_color),
    .wr_byte_en     (wr_byte_en),
    .clear_start    (clear_start),
    .clear_busy     (clear_busy),
    .rd_en          (rd_en),
    .rd_index       (rd_index),
    .rd_color_valid (rd_color_valid),
    .rd_color       (rd_color)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: palette contents, sweep progress, and a 2-deep lookup delay line.
  logic [15:0] m_mem [PL];
  bit          m_clearing;
  int          m_ptr;
  bit          m_pv0 [2];
  bit          m_pv1 [2];
  bit          m_ov  [2];
  logic [15:0] m_pc0 [2];
  logic [15:0] m_pc1 [2];
  logic [15:0] m_oc  [2];

  task automatic model_step();
    if (!reset_n) begin
      m_clearing = 1'b1;
      m_ptr      = 0;
      for (int c = 0; c < 2; c++) begin
        m_pv0[c] = 1'b0; m_pv1[c] = 1'b0; m_ov[c] = 1'b0; m_oc[c] = 16'h0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_ov[c] = m_pv1[c];
        if (m_pv1[c]) m_oc[c] = m_pc1[c];
        m_pv1[c] = m_pv0[c];
        m_pc1[c] = m_pc0[c];
        m_pv0[c] = rd_en[c];
        m_pc0[c] = m_mem[rd_index[c*8 +: 8]];
      end
      if (m_clearing) begin
        m_mem[m_ptr] = 16'h0000;
        if (m_ptr == PL - 1) begin
          m_clearing = 1'b0;
          m_ptr      = 0;
        end else begin
          m_ptr++;
        end
      end else begin
        if (wr_valid) begin
          for (int b = 0; b < 2; b++) begin
            if (wr_byte_en[b]) m_mem[wr_index][8*b +: 8] = wr_color[8*b +: 8];
          end
        end
        if (clear_start) begin
          m_clearing = 1'b1;
          m_ptr      = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("wr_ready", 32'(wr_ready), 32'(!m_clearing));
      chk("clear_busy", 32'(clear_busy), 32'(m_clearing));
      chk("rd_valid", 32'(rd_color_valid), 32'({m_ov[1], m_ov[0]}));
      chk("rd_color", rd_color, {m_oc[1], m_oc[0]});
    end
  end

  task automatic step(input logic wv, input logic [7:0] wi, input logic [15:0] wc,
                      input logic [1:0] wb, input logic [1:0] re,
                      input logic [7:0] r0, input logic [7:0] r1);
    @(negedge clk);
    wr_valid    = wv;
    wr_index    = wi;
    wr_color    = wc;
    wr_byte_en  = wb;
    rd_en       = re;
    rd_index    = {r1, r0};
    clear_start = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 8'h0, 16'h0, 2'b00, 2'b00, 8'h0, 8'h0);
  endtask

  task automatic rstep();
    step(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), 2'($urandom),
         2'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Counts rising edges until clear_busy drops, bounded.
  task automatic sweep_len(output int n);
    n = 0;
    while (clear_busy === 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int vcnt;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Power-up sweep length and contents
    sweep_len(n);
    chk("sweep_len_powerup", 32'(n), 32'd256);
    for (int i = 0; i < PL; i++) step(1'b0, 8'h0, 16'h0, 2'b00, 2'b11, 8'(i), 8'(PL - 1 - i));
    idle(); idle(); idle();
    step(1'b0, 8'h0, 16'h0, 2'b00, 2'b11, 8'd0, 8'd255);
    idle(); idle(); idle();
    chk("clear_val_valid", 32'(rd_color_valid), 32'h3);
    chk("clear_val_color", rd_color, 32'h0000_0000);

    // Full write then read on both channels
    step(1'b1, 8'd5, 16'hABCD, 2'b11, 2'b00, 8'd0, 8'd0);
    step(1'b0, 8'd0, 16'h0, 2'b00, 2'b11, 8'd5, 8'd5);
    idle(); idle(); idle();
    chk("wr5_valid", 32'(rd_color_valid), 32'h3);
    chk("wr5_color", rd_color, 32'hABCD_ABCD);

    // Byte-masked update of the upper byte only
    step(1'b1, 8'd7, 16'h1234, 2'b11, 2'b00, 8'd0, 8'd0);
    step(1'b1, 8'd7, 16'hFF00, 2'b10, 2'b00, 8'd0, 8'd0);
    step(1'b0, 8'd0, 16'h0, 2'b00, 2'b01, 8'd7, 8'd0);
    idle(); idle(); idle();
    chk("mask_valid", 32'(rd_color_valid), 32'h1);
    chk("mask_color", 32'(rd_color[15:0]), 32'hFF34);

    // Same-edge collision is read-first; next edge sees the new value
    step(1'b1, 8'd9, 16'h5555, 2'b11, 2'b01, 8'd9, 8'd0);
    step(1'b0, 8'd0, 16'h0, 2'b00, 2'b01, 8'd9, 8'd0);
    idle(); idle();
    chk("coll_old_valid", 32'(rd_color_valid), 32'h1);
    chk("coll_old_color", 32'(rd_color[15:0]), 32'h0000);
    idle();
    chk("coll_new_color", 32'(rd_color[15:0]), 32'h5555);

    // Back-to-back lookups with random writes; one result per cycle on each channel
    vcnt = 0;
    for (int i = 0; i < PL; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), 2'($urandom),
           2'b11, 8'(i), 8'($urandom));
      if (i >= 3 && rd_color_valid == 2'b11) vcnt++;
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      if (rd_color_valid == 2'b11) vcnt++;
    end
    chk("b2b_valid_count", 32'(vcnt), 32'd256);

    // Random traffic, then host clear, ignored re-trigger, and reset mid-sweep
    repeat (200) rstep();
    repeat (20) rstep();
    rstep();
    clear_start = 1'b1;
    repeat (100) rstep();
    rstep();
    clear_start = 1'b1;
    repeat (48) rstep();
    chk("busy_mid_sweep", 32'(clear_busy), 32'h1);
    @(negedge clk);
    reset_n     = 1'b0;
    wr_valid    = 1'b0;
    rd_en       = 2'b00;
    clear_start = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(rd_color_valid), 32'h0);
    chk("rst_busy", 32'(clear_busy), 32'h1);
    chk("rst_ready", 32'(wr_ready), 32'h0);
    chk("rst_color", rd_color, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    sweep_len(n);
    chk("sweep_len_after_reset", 32'(n), 32'd256);

    repeat (300) rstep();
    idle(); idle(); idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
